// File: rtl/ddr_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : ddr_tx_if
// Description : Bus bundle between the DDR CCC engine / SCL generator / CRC5
//               engine side and the HDR-DDR serializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface ddr_tx_if;
    logic       i_sclgen_scl_pos_edge;
    logic       i_sclgen_scl_neg_edge;
    logic       i_ddrccc_tx_en;
    logic [2:0] i_ddrccc_tx_mode;
    logic [7:0] i_regf_tx_data;
    logic [4:0] i_crc_value;
    logic       o_sdahnd_tx_sda;
    logic       o_ddrccc_tx_mode_done;
    logic       o_crc_en;
    logic       o_crc_data_valid;
    logic [7:0] o_crc_data;

    // Serializer side
    modport slave (
        input  i_sclgen_scl_pos_edge, i_sclgen_scl_neg_edge,
        input  i_ddrccc_tx_en, i_ddrccc_tx_mode,
        input  i_regf_tx_data, i_crc_value,
        output o_sdahnd_tx_sda, o_ddrccc_tx_mode_done,
        output o_crc_en, o_crc_data_valid, o_crc_data
    );

    // Engine / surrounding datapath side
    modport master (
        output i_sclgen_scl_pos_edge, i_sclgen_scl_neg_edge,
        output i_ddrccc_tx_en, i_ddrccc_tx_mode,
        output i_regf_tx_data, i_crc_value,
        input  o_sdahnd_tx_sda, o_ddrccc_tx_mode_done,
        input  o_crc_en, o_crc_data_valid, o_crc_data
    );
endinterface
`default_nettype wire

// File: rtl/ddr_tx.sv
`default_nettype none
// ============================================================================
// Module      : ddr_tx
// Description : HDR-DDR serializer. Shifts the requested field onto SDA one
//               bit per SCL edge, tracks the two data bytes of a word for
//               parity and feeds bytes to the CRC5 engine.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_tx (
    input  wire      i_sys_clk,
    input  wire      i_sys_rst,
    ddr_tx_if.slave  tx_if
);

    localparam logic [2:0] c_MODE_IDLE   = 3'b000;
    localparam logic [2:0] c_MODE_PRE1   = 3'b001;
    localparam logic [2:0] c_MODE_PRE0   = 3'b010;
    localparam logic [2:0] c_MODE_BYTE   = 3'b011;
    localparam logic [2:0] c_MODE_PARITY = 3'b100;
    localparam logic [2:0] c_MODE_TOKEN  = 3'b101;
    localparam logic [2:0] c_MODE_CRC    = 3'b110;
    localparam logic [2:0] c_MODE_RSVD   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_prev_en;
    logic [2:0]  r_prev_mode;
    logic [2:0]  r_field;
    logic [7:0]  r_shift;
    logic [2:0]  r_len;
    logic [2:0]  r_count;
    logic [15:0] r_word;
    logic        r_byte_num;
    logic        r_pre_seen;
    logic        r_sda;
    logic        r_crc_en;
    logic        r_crc_valid;
    logic [7:0]  r_crc_data;

    wire         w_en     = tx_if.i_ddrccc_tx_en;
    wire  [2:0]  w_mode   = tx_if.i_ddrccc_tx_mode;
    wire         w_strobe = tx_if.i_sclgen_scl_pos_edge | tx_if.i_sclgen_scl_neg_edge;
    wire         w_active = (w_mode != c_MODE_IDLE) && (w_mode != c_MODE_RSVD);
    wire         w_change = ({w_en, w_mode} != {r_prev_en, r_prev_mode});
    wire         w_load   = w_en && w_active && w_change;
    wire         w_last   = (r_count == r_len);
    // Word parity: P1 over odd bit positions, P0 over even positions inverted
    wire         w_p1     = ^(r_word & 16'hAAAA);
    wire         w_p0     = ~(^(r_word & 16'h5555));

    // Field FSM state register
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    // Next-state: disable and mode changes take priority over edge strobes
    always_comb begin
        w_state_nxt = r_state;
        if (!w_en)
            w_state_nxt = ST_IDLE;
        else if (w_load)
            w_state_nxt = ST_LOAD;
        else if (!w_active)
            w_state_nxt = ST_IDLE;
        else begin
            case (r_state)
                ST_LOAD:  w_state_nxt = ST_SHIFT;
                ST_SHIFT: if (w_strobe && w_last) w_state_nxt = ST_DONE;
                ST_DONE:  w_state_nxt = ST_IDLE;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    // Field capture, bit shifting, word tracking and CRC feed
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            r_prev_en   <= 1'b0;
            r_prev_mode <= c_MODE_IDLE;
            r_field     <= c_MODE_IDLE;
            r_shift     <= 8'h00;
            r_len       <= 3'd0;
            r_count     <= 3'd0;
            r_word      <= 16'h0000;
            r_byte_num  <= 1'b0;
            r_pre_seen  <= 1'b0;
            r_sda       <= 1'b1;
            r_crc_en    <= 1'b0;
            r_crc_valid <= 1'b0;
            r_crc_data  <= 8'h00;
        end else begin
            r_prev_en   <= w_en;
            r_prev_mode <= w_mode;
            r_crc_valid <= 1'b0;
            if (!w_en) begin
                r_count    <= 3'd0;
                r_sda      <= 1'b1;
                r_byte_num <= 1'b0;
                r_word     <= 16'h0000;
                r_crc_en   <= 1'b0;
                r_pre_seen <= 1'b0;
            end else begin
                // CRC phase ends on the cycle after the CRC value field is done
                if (r_state == ST_DONE && r_field == c_MODE_CRC)
                    r_crc_en <= 1'b0;
                if (w_load) begin
                    r_field <= w_mode;
                    r_count <= 3'd0;
                    case (w_mode)
                        c_MODE_PRE1: begin
                            r_shift    <= 8'h80;
                            r_len      <= 3'd0;
                            r_pre_seen <= 1'b1;
                        end
                        c_MODE_PRE0: begin
                            r_shift    <= 8'h00;
                            r_len      <= 3'd0;
                            r_pre_seen <= 1'b1;
                        end
                        c_MODE_BYTE: begin
                            r_shift     <= tx_if.i_regf_tx_data;
                            r_len       <= 3'd7;
                            r_crc_data  <= tx_if.i_regf_tx_data;
                            r_crc_valid <= 1'b1;
                            if (r_byte_num) r_word[7:0]  <= tx_if.i_regf_tx_data;
                            else            r_word[15:8] <= tx_if.i_regf_tx_data;
                            if (r_pre_seen) begin
                                r_crc_en   <= 1'b1;
                                r_pre_seen <= 1'b0;
                            end
                        end
                        c_MODE_PARITY: begin
                            r_shift <= {w_p1, w_p0, 6'b000000};
                            r_len   <= 3'd1;
                        end
                        c_MODE_TOKEN: begin
                            r_shift <= 8'hC0;
                            r_len   <= 3'd3;
                        end
                        c_MODE_CRC: begin
                            r_shift <= {tx_if.i_crc_value, 3'b000};
                            r_len   <= 3'd4;
                        end
                        default: begin
                            r_shift <= 8'hFF;
                            r_len   <= 3'd0;
                        end
                    endcase
                end else if (!w_active) begin
                    r_sda   <= 1'b1;
                    r_count <= 3'd0;
                end else begin
                    case (r_state)
                        ST_LOAD: begin
                            r_sda   <= r_shift[7];
                            r_shift <= {r_shift[6:0], 1'b0};
                        end
                        ST_SHIFT: begin
                            if (w_strobe) begin
                                if (w_last) begin
                                    if (r_field == c_MODE_BYTE)
                                        r_byte_num <= ~r_byte_num;
                                    else if (r_field == c_MODE_PARITY)
                                        r_byte_num <= 1'b0;
                                end else begin
                                    r_sda   <= r_shift[7];
                                    r_shift <= {r_shift[6:0], 1'b0};
                                    r_count <= r_count + 3'd1;
                                end
                            end
                        end
                        default: begin
                            r_sda <= r_sda;
                        end
                    endcase
                end
            end
        end
    end

    assign tx_if.o_sdahnd_tx_sda       = r_sda;
    assign tx_if.o_ddrccc_tx_mode_done = (r_state == ST_DONE);
    assign tx_if.o_crc_en              = r_crc_en;
    assign tx_if.o_crc_data_valid      = r_crc_valid;
    assign tx_if.o_crc_data            = r_crc_data;

endmodule
`default_nettype wire

// File: tb/tb_ddr_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_tx
// Description : Directed self-checking bench for the HDR-DDR serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_tx;

    localparam logic [2:0] c_MODE_IDLE   = 3'b000;
    localparam logic [2:0] c_MODE_PRE1   = 3'b001;
    localparam logic [2:0] c_MODE_PRE0   = 3'b010;
    localparam logic [2:0] c_MODE_BYTE   = 3'b011;
    localparam logic [2:0] c_MODE_PARITY = 3'b100;
    localparam logic [2:0] c_MODE_TOKEN  = 3'b101;
    localparam logic [2:0] c_MODE_CRC    = 3'b110;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic crc_en_at_done;

    ddr_tx_if tx_if ();

    ddr_tx dut (
        .i_sys_clk (clk),
        .i_sys_rst (rst),
        .tx_if     (tx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int k);
        if (k % 2 == 1) tx_if.i_sclgen_scl_pos_edge = 1'b1;
        else            tx_if.i_sclgen_scl_neg_edge = 1'b1;
        tick();
        tx_if.i_sclgen_scl_pos_edge = 1'b0;
        tx_if.i_sclgen_scl_neg_edge = 1'b0;
    endtask

    // Presents one field, checks LOAD-cycle CRC feed, every SDA bit, the done
    // pulse timing, then returns the mode to IDLE.
    task automatic run_field(input logic [2:0] m, input logic [7:0] data,
                             input logic [4:0] crc, input logic [7:0] exp,
                             input int n, input string tag);
        tx_if.i_regf_tx_data   = data;
        tx_if.i_crc_value      = crc;
        tx_if.i_ddrccc_tx_mode = m;
        tick();
        if (m == c_MODE_BYTE) begin
            check_val({tag, "_crc_valid"}, 8'(tx_if.o_crc_data_valid), 8'd1);
            check_val({tag, "_crc_data"}, tx_if.o_crc_data, data);
        end
        tick();
        check_val({tag, "_bit0"}, 8'(tx_if.o_sdahnd_tx_sda), 8'(exp[7]));
        for (int k = 1; k <= n; k++) begin
            strobe(k);
            if (k < n) begin
                check_val($sformatf("%s_bit%0d", tag, k), 8'(tx_if.o_sdahnd_tx_sda), 8'(exp[7-k]));
                check_val($sformatf("%s_nodone%0d", tag, k), 8'(tx_if.o_ddrccc_tx_mode_done), 8'd0);
            end else begin
                check_val({tag, "_done"}, 8'(tx_if.o_ddrccc_tx_mode_done), 8'd1);
                check_val({tag, "_hold"}, 8'(tx_if.o_sdahnd_tx_sda), 8'(exp[8-n]));
            end
        end
        crc_en_at_done = tx_if.o_crc_en;
        tx_if.i_ddrccc_tx_mode = c_MODE_IDLE;
        tick();
        check_val({tag, "_done_clr"}, 8'(tx_if.o_ddrccc_tx_mode_done), 8'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        tx_if.i_sclgen_scl_pos_edge = 1'b0;
        tx_if.i_sclgen_scl_neg_edge = 1'b0;
        tx_if.i_ddrccc_tx_en        = 1'b0;
        tx_if.i_ddrccc_tx_mode      = c_MODE_IDLE;
        tx_if.i_regf_tx_data        = 8'h00;
        tx_if.i_crc_value           = 5'h00;
        tick();
        tick();
        check_val("rst_sda", 8'(tx_if.o_sdahnd_tx_sda), 8'd1);
        check_val("rst_done", 8'(tx_if.o_ddrccc_tx_mode_done), 8'd0);
        check_val("rst_crc_en", 8'(tx_if.o_crc_en), 8'd0);
        check_val("rst_crc_valid", 8'(tx_if.o_crc_data_valid), 8'd0);
        check_val("rst_crc_data", tx_if.o_crc_data, 8'h00);
        rst = 1'b1;
        tick();
        tx_if.i_ddrccc_tx_en = 1'b1;
        tick();

        // Preamble bits
        run_field(c_MODE_PRE1, 8'h00, 5'h00, 8'h80, 1, "pre1");
        run_field(c_MODE_PRE0, 8'h00, 5'h00, 8'h00, 1, "pre0");

        // First data word: A5, 00 -> parity {0,1}
        run_field(c_MODE_BYTE, 8'hA5, 5'h00, 8'hA5, 8, "byteA5");
        check_val("crc_en_set", 8'(tx_if.o_crc_en), 8'd1);
        run_field(c_MODE_BYTE, 8'h00, 5'h00, 8'h00, 8, "byte00");
        run_field(c_MODE_PARITY, 8'h00, 5'h00, 8'h40, 2, "parA500");
        check_val("bytenum_par1", 8'(dut.r_byte_num), 8'd0);

        // Second data word: 12, 34 -> parity {0,0}
        run_field(c_MODE_BYTE, 8'h12, 5'h00, 8'h12, 8, "byte12");
        check_val("bytenum_mid", 8'(dut.r_byte_num), 8'd1);
        run_field(c_MODE_BYTE, 8'h34, 5'h00, 8'h34, 8, "byte34");
        run_field(c_MODE_PARITY, 8'h00, 5'h00, 8'h00, 2, "par1234");
        check_val("bytenum_par2", 8'(dut.r_byte_num), 8'd0);

        // CRC token and value 1B; crc_en drops the cycle after done
        run_field(c_MODE_TOKEN, 8'h00, 5'h00, 8'hC0, 4, "token");
        run_field(c_MODE_CRC, 8'h00, 5'h1B, 8'hD8, 5, "crc1B");
        check_val("crc_en_at_done", 8'(crc_en_at_done), 8'd1);
        check_val("crc_en_fall", 8'(tx_if.o_crc_en), 8'd0);

        // Abort byte 3C after three strobes
        tx_if.i_regf_tx_data   = 8'h3C;
        tx_if.i_ddrccc_tx_mode = c_MODE_BYTE;
        tick();
        tick();
        check_val("abort_bit0", 8'(tx_if.o_sdahnd_tx_sda), 8'd0);
        for (int k = 1; k <= 3; k++) strobe(k);
        check_val("abort_bit3", 8'(tx_if.o_sdahnd_tx_sda), 8'd1);
        tx_if.i_ddrccc_tx_en = 1'b0;
        tick();
        check_val("abort_sda", 8'(tx_if.o_sdahnd_tx_sda), 8'd1);
        check_val("abort_done", 8'(tx_if.o_ddrccc_tx_mode_done), 8'd0);
        for (int k = 4; k <= 8; k++) strobe(k);
        check_val("abort_nodone", 8'(tx_if.o_ddrccc_tx_mode_done), 8'd0);
        check_val("abort_sda2", 8'(tx_if.o_sdahnd_tx_sda), 8'd1);

        // Re-enable: full byte 3C lands as byte0, no CRC phase without preamble
        tx_if.i_ddrccc_tx_en = 1'b1;
        run_field(c_MODE_BYTE, 8'h3C, 5'h00, 8'h3C, 8, "byte3C");
        check_val("bytenum_3C", 8'(dut.r_byte_num), 8'd1);
        check_val("crc_en_nopre", 8'(tx_if.o_crc_en), 8'd0);
        run_field(c_MODE_BYTE, 8'h01, 5'h00, 8'h01, 8, "byte01");
        run_field(c_MODE_PARITY, 8'h00, 5'h00, 8'h00, 2, "par3C01");

        // Reset asserted mid-byte FF during a CRC phase
        run_field(c_MODE_PRE1, 8'h00, 5'h00, 8'h80, 1, "pre1b");
        tx_if.i_regf_tx_data   = 8'hFF;
        tx_if.i_ddrccc_tx_mode = c_MODE_BYTE;
        tick();
        check_val("ff_crc_en", 8'(tx_if.o_crc_en), 8'd1);
        tick();
        strobe(1);
        strobe(2);
        check_val("ff_bit2", 8'(tx_if.o_sdahnd_tx_sda), 8'd1);
        rst = 1'b0;
        tx_if.i_ddrccc_tx_en   = 1'b0;
        tx_if.i_ddrccc_tx_mode = c_MODE_IDLE;
        tick();
        check_val("rst2_sda", 8'(tx_if.o_sdahnd_tx_sda), 8'd1);
        check_val("rst2_done", 8'(tx_if.o_ddrccc_tx_mode_done), 8'd0);
        check_val("rst2_crc_en", 8'(tx_if.o_crc_en), 8'd0);
        rst = 1'b1;
        tick();
        strobe(1);
        check_val("rst2_state", 8'(dut.r_state), 8'd0);
        check_val("rst2_idle_done", 8'(tx_if.o_ddrccc_tx_mode_done), 8'd0);
        check_val("rst2_idle_sda", 8'(tx_if.o_sdahnd_tx_sda), 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr_tx.md
# ddr_tx

HDR-DDR serializer for the I3C controller datapath; the transmit counterpart of the DDR receiver. It drives SDA one bit per SCL edge (both edges) under command of the DDR CCC engine. It sequences whatever field the engine requests: preamble bits, 8-bit data bytes, the 2-bit parity, the CRC token and the 5-bit CRC value. It also captures the two data bytes of each word for parity and feeds bytes to the CRC5 engine.

## Interface
Parameters:
- none

Ports:
- i_sys_clk  in  1  system clock; all logic on rising edge
- i_sys_rst  in  1  asynchronous, active-low reset
- i_sclgen_scl_pos_edge  in  1  one-cycle strobe, SCL rising edge
- i_sclgen_scl_neg_edge  in  1  one-cycle strobe, SCL falling edge
- i_ddrccc_tx_en  in  1  block enable from DDR CCC engine
- i_ddrccc_tx_mode  in  3  field to transmit (encoding below)
- i_regf_tx_data  in  8  data byte, sampled at SERIAL_BYTE field start
- i_crc_value  in  5  CRC5 result, sampled at CRC_VALUE field start
- o_sdahnd_tx_sda  out  1  serial data to SDA handler
- o_ddrccc_tx_mode_done  out  1  one-cycle pulse, field complete
- o_crc_en  out  1  CRC engine enable, high across the data phase
- o_crc_data_valid  out  1  one-cycle pulse, o_crc_data valid
- o_crc_data  out  8  byte passed to CRC engine

## Operation
- Mode encoding and field contents (MSB first, bit index n = 0 first):
  - 000 IDLE: SDA=1, 0 bits, no done.
  - 001 PRE_ONE: 1 bit, value 1.
  - 010 PRE_ZERO: 1 bit, value 0.
  - 011 SERIAL_BYTE: 8 bits of the captured byte, bit 7 first.
  - 100 PARITY: 2 bits {P1,P0} over word W = {byte0, byte1}.
    - P1 = XOR of W[15,13,11,9,7,5,3,1].
    - P0 = XOR of W[14,12,10,8,6,4,2,0] ^ 1.
  - 101 CRC_TOKEN: 4 bits, 4'hC.
  - 110 CRC_VALUE: 5 bits of the captured i_crc_value, bit 4 first.
  - 111: reserved, treated as IDLE.
- Field FSM states: IDLE → LOAD → SHIFT → DONE → IDLE.
  - LOAD occurs on any change of the (tx_en, mode) pair to an enabled non-IDLE mode.
  - LOAD sets count=0 and captures the field contents.
  - In SHIFT, each edge strobe (pos OR neg) advances count.
  - When count reaches N−1 and an edge strobe arrives, go to DONE.
  - DONE pulses done for 1 cycle; the FSM then waits in IDLE for a mode change.
  - SDA holds the last bit while waiting.
- Byte tracking: 1-bit byte_num.
  - SERIAL_BYTE LOAD stores the byte into W[15:8] if byte_num=0, otherwise into W[7:0].
  - byte_num toggles at each SERIAL_BYTE DONE.
  - PARITY DONE clears byte_num.
- CRC feed:
  - Every SERIAL_BYTE LOAD pulses o_crc_data_valid with o_crc_data = captured byte.
  - o_crc_en is set at the first SERIAL_BYTE LOAD after a PRE_ONE/PRE_ZERO field.
  - o_crc_en clears at CRC_VALUE DONE.
- Disable (tx_en=0) aborts any field: count=0, SDA=1, done=0, byte_num=0, W=0, o_crc_en=0. No done pulse is issued for the aborted field.
- A mode change while enabled and mid-field abandons the field without a done pulse and LOADs the new field.

## Timing
- Reset values: SDA=1, done=0, o_crc_en=0, o_crc_data_valid=0, o_crc_data=0, count=0, byte_num=0, W=0, FSM=IDLE.
- Bit 0 appears on SDA 1 cycle after the LOAD cycle, i.e. 2 cycles after mode/enable is presented.
- Bit k (k≥1) appears 1 cycle after the k-th edge strobe.
- The done pulse is asserted the cycle after the N-th edge strobe. The engine may change mode in the same cycle it sees done.
- The edge strobe and the mode change can fall in the same cycle. The mode change wins: the strobe is ignored and LOAD occurs.
- pos and neg strobes are never simultaneous. Each strobe counts exactly once.
- o_crc_data_valid coincides with the LOAD cycle of SERIAL_BYTE.
- Parity is computed combinationally from W. It is registered at PARITY LOAD, so the final byte must have completed before PARITY LOAD.

## Test plan
- Reset asserted mid-SERIAL_BYTE with data 0xFF → next cycle SDA=1, done=0, o_crc_en=0; after release the FSM is in IDLE.
- PRE_ONE then PRE_ZERO, one edge each → SDA sequence 1,0. Done pulses once per field, 1 cycle after each strobe.
- SERIAL_BYTE 0xA5, 8 alternating pos/neg strobes → SDA 1,0,1,0,0,1,0,1. One done pulse. o_crc_data_valid with o_crc_data=0xA5 at LOAD.
- Bytes 0xA5, 0x00 then PARITY → SDA 0,1. Bytes 0x12, 0x34 then PARITY → SDA 0,0. byte_num=0 after each PARITY done.
- CRC_TOKEN then CRC_VALUE with i_crc_value=5'h1B → SDA 1,1,0,0 then 1,1,0,1,1. o_crc_en falls the cycle after the CRC_VALUE done.
- tx_en dropped after 3 strobes of byte 0x3C → no done, SDA=1. Re-enable with SERIAL_BYTE 0x3C → full 8 bits 0,0,1,1,1,1,0,0; the byte is stored as byte0.
